taillight_decoder: RTL and testbench
====================================

Name: taillight_decoder

Overview:
- Consumer end of the lamp interface: samples the 3-bit left/right lamp buses (li, ri) each clock.
- Reconstructs which signalling mode is running (left, right, hazard) and checks every pattern step against the legal sequences.
- Used as a bus-side checker next to the turn-signal controller and as a reusable receiver in the layered bench.

Parameters:
- STEP_CYC, 1: clocks each non-idle lamp pattern must be held; legal range 1..15.
- IDLE_MAX, 4: consecutive all-off clocks after which the decoded mode is dropped to NONE.
- CNT_W, 8: width of the saturating sweep and error counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low.
- li  in  3  left lamps; bit0 innermost, lights first.
- ri  in  3  right lamps; bit0 innermost, lights first.
- mode  out  2  decoded mode: 0 NONE, 1 LEFT, 2 RIGHT, 3 HAZ.
- mode_valid  out  1  high while mode reflects a completed sweep.
- sweep_done  out  1  one-cycle pulse when a legal sweep completes.
- err  out  1  one-cycle pulse on any illegal observation.
- sweep_cnt  out  CNT_W  completed sweeps, saturating.
- err_cnt  out  CNT_W  errors, saturating.

Behaviour:
- Reset: rst=0 at a rising edge sets FSM=IDLE, hold and idle counters=0, mode=0, mode_valid=0, sweep_done=0, err=0, sweep_cnt=0, err_cnt=0. Reset is valid mid-sweep; no pulse is emitted for the abandoned sweep.
- Observation: obs = {li,ri} is registered in the same cycle. All outputs are registered, so there is 1 clock of latency from the sample edge.
- FSM states: IDLE, L1(001/000), L2(011/000), L3(111/000), R1(000/001), R2(000/011), R3(000/111), HZ(111/111), SYNC.
- Hold rule:
  - In any lit state, obs equal to the current pattern increments hold_cnt.
  - hold_cnt reaching STEP_CYC with obs unchanged is an error (over-hold).
  - Leaving a lit state with hold_cnt < STEP_CYC-1 is an error (under-hold).
- Legal transitions, taken only after exactly STEP_CYC clocks in the lit state:
  - IDLE to L1, R1 or HZ.
  - L1 to L2, L2 to L3, L3 to IDLE (LEFT sweep complete).
  - R1 to R2, R2 to R3, R3 to IDLE (RIGHT sweep complete).
  - HZ to IDLE (HAZ sweep complete).
- Idle hold: IDLE may be held any length; idle_cnt counts consecutive all-off clocks and saturates at IDLE_MAX.
- Sweep completion:
  - sweep_done pulses for 1 clock.
  - sweep_cnt increments, holding at all-ones.
  - mode is set to the sweep type and mode_valid=1.
- Mode change: a completed sweep of a different type overwrites mode in the same cycle, with no NONE gap.
- Idle timeout: when idle_cnt reaches IDLE_MAX, mode=0 and mode_valid=0 on the next clock.
- Error handling:
  - Any other obs, or a hold violation, pulses err for 1 clock and increments err_cnt (saturating).
  - Resync: if obs is a legal first step (001/000, 000/001, 111/111), go to that state with hold_cnt=0.
  - If obs is 000/000, go to IDLE; otherwise go to SYNC.
  - mode and mode_valid are left unchanged.
- SYNC: wait for 000/000, then go to IDLE. No further err pulses while in SYNC.
- Simultaneous events: an error in the cycle a sweep would complete suppresses sweep_done.
- Counter saturation: sweep_cnt and err_cnt each hold at 2^CNT_W-1.

Optional Feature:
- Macro TLDEC_ERRCODE_EN.
- Defined: adds output err_code, 3 bits, registered alongside err and held until the next error or reset. Codes: 1 illegal pattern, 2 over-hold, 3 under-hold, 4 illegal first step from IDLE.
- Undefined: no err_code port and no code logic; all other behaviour is identical.

Decomposition:
- Package tl_pkg holds:
  - mode_e enum (NONE, LEFT, RIGHT, HAZ).
  - dec_state_e enum.
  - Lamp pattern constants PAT_OFF=3'b000, PAT_1=3'b001, PAT_2=3'b011, PAT_3=3'b111.
  - err code constants.
- One sub-module, tl_sat_counter (parameterised width, inc, saturating), instantiated twice for sweep_cnt and err_cnt.

Test Plan:
- Reset: hold rst=0 for 2 clocks with li=ri=3'b111 -> all outputs 0; first clock after release gives err=0 and FSM=SYNC.
- Left sweep, STEP_CYC=1: 000/000, 001/000, 011/000, 111/000, 000/000 -> sweep_done pulse on the clock after the final 000/000 sample; mode=1, mode_valid=1, sweep_cnt=1, err=0.
- Right then hazard with no gap: right sweep then 111/111, 000/000 -> mode 2 then 3 with no NONE gap; sweep_cnt=2.
- Idle timeout, IDLE_MAX=4: after a left sweep, hold 000/000 for 4 clocks -> mode=0, mode_valid=0; sweep_cnt unchanged.
- Illegal step: 001/000 then 111/000 (skips 011) -> err pulse, err_cnt=1, FSM=SYNC; next 000/000 -> IDLE; mode unchanged.
- Hold rule, STEP_CYC=2: 001/000 held 3 clocks -> err at 3rd sample (code 2 with TLDEC_ERRCODE_EN); 001/000 held 1 clock then 011/000 -> err (code 3).

Source files
------------

// File: rtl/taillight_decoder_pkg.sv
// tl_pkg: shared types, lamp patterns and step helpers for the taillight decoder.
// Optional build macro TLDEC_ERRCODE_EN enables the err_code output.
package tl_pkg;

    typedef enum logic [1:0] {
        MODE_NONE  = 2'd0,
        MODE_LEFT  = 2'd1,
        MODE_RIGHT = 2'd2,
        MODE_HAZ   = 2'd3
    } mode_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_L1,
        ST_L2,
        ST_L3,
        ST_R1,
        ST_R2,
        ST_R3,
        ST_HZ,
        ST_SYNC
    } dec_state_e;

    localparam logic [2:0] PAT_OFF = 3'b000;
    localparam logic [2:0] PAT_1   = 3'b001;
    localparam logic [2:0] PAT_2   = 3'b011;
    localparam logic [2:0] PAT_3   = 3'b111;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_ILLEGAL   = 3'd1;
    localparam logic [2:0] ERR_OVERHOLD  = 3'd2;
    localparam logic [2:0] ERR_UNDERHOLD = 3'd3;
    localparam logic [2:0] ERR_FIRST     = 3'd4;

    // {li,ri} shown while a lit state is held
    function automatic logic [5:0] state_pat(dec_state_e s);
        logic [5:0] p;
        unique case (s)
            ST_L1:   p = {PAT_1, PAT_OFF};
            ST_L2:   p = {PAT_2, PAT_OFF};
            ST_L3:   p = {PAT_3, PAT_OFF};
            ST_R1:   p = {PAT_OFF, PAT_1};
            ST_R2:   p = {PAT_OFF, PAT_2};
            ST_R3:   p = {PAT_OFF, PAT_3};
            ST_HZ:   p = {PAT_3, PAT_3};
            default: p = '0;
        endcase
        return p;
    endfunction

    // pattern that legally follows a lit state (all-off ends a sweep)
    function automatic logic [5:0] succ_pat(dec_state_e s);
        logic [5:0] p;
        unique case (s)
            ST_L1:   p = {PAT_2, PAT_OFF};
            ST_L2:   p = {PAT_3, PAT_OFF};
            ST_R1:   p = {PAT_OFF, PAT_2};
            ST_R2:   p = {PAT_OFF, PAT_3};
            default: p = '0;
        endcase
        return p;
    endfunction

    function automatic dec_state_e succ_state(dec_state_e s);
        dec_state_e n;
        unique case (s)
            ST_L1:   n = ST_L2;
            ST_L2:   n = ST_L3;
            ST_R1:   n = ST_R2;
            ST_R2:   n = ST_R3;
            default: n = ST_IDLE;
        endcase
        return n;
    endfunction

    // sweep type finished when leaving this state to all-off
    function automatic mode_e sweep_mode(dec_state_e s);
        mode_e m;
        unique case (s)
            ST_L3:   m = MODE_LEFT;
            ST_R3:   m = MODE_RIGHT;
            ST_HZ:   m = MODE_HAZ;
            default: m = MODE_NONE;
        endcase
        return m;
    endfunction

    // where to land after an error or a fresh start from idle
    function automatic dec_state_e entry_state(logic [5:0] obs);
        dec_state_e n;
        unique case (obs)
            {PAT_1, PAT_OFF}:   n = ST_L1;
            {PAT_OFF, PAT_1}:   n = ST_R1;
            {PAT_3, PAT_3}:     n = ST_HZ;
            {PAT_OFF, PAT_OFF}: n = ST_IDLE;
            default:            n = ST_SYNC;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/taillight_decoder_if.sv
// Lamp bus plus decoder status, shared by lamp driver and decoder.
// Optional build macro TLDEC_ERRCODE_EN adds err_code.
interface taillight_decoder_if #(
    parameter int CNT_W = 8
);
    logic [2:0]       li;
    logic [2:0]       ri;
    logic [1:0]       mode;
    logic             mode_valid;
    logic             sweep_done;
    logic             err;
    logic [CNT_W-1:0] sweep_cnt;
    logic [CNT_W-1:0] err_cnt;
`ifdef TLDEC_ERRCODE_EN
    logic [2:0]       err_code;

    modport master (
        output li, ri,
        input  mode, mode_valid, sweep_done, err,
        input  sweep_cnt, err_cnt, err_code
    );
    modport slave (
        input  li, ri,
        output mode, mode_valid, sweep_done, err,
        output sweep_cnt, err_cnt, err_code
    );
`else
    modport master (
        output li, ri,
        input  mode, mode_valid, sweep_done, err,
        input  sweep_cnt, err_cnt
    );
    modport slave (
        input  li, ri,
        output mode, mode_valid, sweep_done, err,
        output sweep_cnt, err_cnt
    );
`endif
endinterface

// File: rtl/taillight_decoder_sat_counter.sv
// tl_sat_counter: event counter that sticks at all-ones.
// Used for the sweep and error tallies of taillight_decoder.
module tl_sat_counter
    import tl_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // bump on request unless already at the ceiling
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // count register, synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/taillight_decoder.sv
// taillight_decoder: watches li/ri, rebuilds the signalling mode, flags bad steps.
// Optional build macro TLDEC_ERRCODE_EN adds a held err_code output.
module taillight_decoder
    import tl_pkg::*;
#(
    parameter int STEP_CYC = 1,
    parameter int IDLE_MAX = 4,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    taillight_decoder_if.slave bus
);
    localparam int IW = $clog2(IDLE_MAX + 1);
    localparam logic [3:0]    HOLD_LAST = 4'(STEP_CYC - 1);
    localparam logic [IW-1:0] IDLE_TOP  = IW'(IDLE_MAX);

    logic [5:0]       obs;
    dec_state_e       state_q, state_d;
    logic [3:0]       hold_q, hold_d;
    logic [IW-1:0]    idle_q, idle_d;
    mode_e            mode_q, mode_d;
    logic             mvalid_q, mvalid_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [2:0]       fault_d;
    logic [CNT_W-1:0] sweep_cnt_w;
    logic [CNT_W-1:0] err_cnt_w;

    assign obs = {bus.li, bus.ri};

    // step checker: classify each sample against the current lamp state
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        mode_d   = mode_q;
        mvalid_d = mvalid_q;
        done_d   = 1'b0;
        fault_d  = ERR_NONE;
        idle_d   = '0;
        if (obs == '0) begin
            idle_d = (idle_q == IDLE_TOP) ? idle_q : idle_q + 1'b1;
        end
        if (idle_q == IDLE_TOP) begin
            mode_d   = MODE_NONE;
            mvalid_d = 1'b0;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (obs != '0) begin
                    // idle_q==0 here only straight after reset: no
                    // all-off seen yet, so we may be mid-sweep
                    if (idle_q == '0) begin
                        state_d = ST_SYNC;
                    end else begin
                        state_d = entry_state(obs);
                        hold_d  = '0;
                        if (entry_state(obs) == ST_SYNC) begin
                            fault_d = ERR_FIRST;
                        end
                    end
                end
            end
            ST_SYNC: begin
                if (obs == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (obs == state_pat(state_q)) begin
                    if (hold_q == HOLD_LAST) begin
                        fault_d = ERR_OVERHOLD;
                        state_d = entry_state(obs);
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end else if (hold_q < HOLD_LAST) begin
                    fault_d = ERR_UNDERHOLD;
                    state_d = entry_state(obs);
                    hold_d  = '0;
                end else if (obs == succ_pat(state_q)) begin
                    state_d = succ_state(state_q);
                    hold_d  = '0;
                    if (succ_state(state_q) == ST_IDLE) begin
                        done_d   = 1'b1;
                        mode_d   = sweep_mode(state_q);
                        mvalid_d = 1'b1;
                    end
                end else begin
                    fault_d = ERR_ILLEGAL;
                    state_d = entry_state(obs);
                    hold_d  = '0;
                end
            end
        endcase
        err_d = (fault_d != ERR_NONE);
    end

    // state and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            idle_q   <= '0;
            mode_q   <= MODE_NONE;
            mvalid_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            idle_q   <= idle_d;
            mode_q   <= mode_d;
            mvalid_q <= mvalid_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

`ifdef TLDEC_ERRCODE_EN
    logic [2:0] code_q;

    // last error cause, kept until the next error
    always_ff @(posedge clk) begin
        if (!rst) begin
            code_q <= ERR_NONE;
        end else if (err_d) begin
            code_q <= fault_d;
        end
    end

    assign bus.err_code = code_q;
`endif

    tl_sat_counter #(.W(CNT_W)) u_sweep_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (done_d),
        .cnt_o (sweep_cnt_w)
    );

    tl_sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (err_d),
        .cnt_o (err_cnt_w)
    );

    assign bus.mode       = mode_q;
    assign bus.mode_valid = mvalid_q;
    assign bus.sweep_done = done_q;
    assign bus.err        = err_q;
    assign bus.sweep_cnt  = sweep_cnt_w;
    assign bus.err_cnt    = err_cnt_w;

endmodule

// File: tb/tb_taillight_decoder.sv
// Bench for taillight_decoder: two parameter sets driven by one lamp stream.
// A sequence-table model predicts every registered output each cycle.
module tb_taillight_decoder;
    import tl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    taillight_decoder_if #(.CNT_W(8)) bus0 ();
    taillight_decoder_if #(.CNT_W(3)) bus1 ();

    taillight_decoder #(.STEP_CYC(1), .IDLE_MAX(4), .CNT_W(8)) u0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    taillight_decoder #(.STEP_CYC(2), .IDLE_MAX(2), .CNT_W(3)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    localparam int K_IDLE = 0;
    localparam int K_SYNC = 4;

    int n_chk = 0;
    int n_err = 0;

    int step_c [2] = '{1, 2};
    int idle_c [2] = '{4, 2};
    int max_c  [2] = '{255, 7};

    logic [5:0] seq [1:3][0:2];
    int seq_len [1:3] = '{3, 3, 1};

    int kind [2];
    int pos [2];
    int run [2];
    int offrun [2];
    bit seen [2];
    int e_mode [2];
    int e_valid [2];
    int e_done [2];
    int e_err [2];
    int e_scnt [2];
    int e_ecnt [2];
    int e_code [2];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int starter(input logic [5:0] o);
        for (int k = 1; k <= 3; k++) begin
            if (seq[k][0] == o) return k;
        end
        return 0;
    endfunction

    task automatic resync(input int i, input logic [5:0] o);
        int k;
        k = starter(o);
        if (k != 0) begin
            kind[i] = k;
            pos[i]  = 0;
            run[i]  = 1;
        end else if (o == 6'd0) begin
            kind[i] = K_IDLE;
        end else begin
            kind[i] = K_SYNC;
        end
    endtask

    task automatic model(input int i, input logic [5:0] o, input bit r);
        int fault;
        int k;
        fault     = 0;
        e_done[i] = 0;
        e_err[i]  = 0;
        if (!r) begin
            kind[i] = K_IDLE; pos[i] = 0; run[i] = 0;
            offrun[i] = 0; seen[i] = 1'b0;
            e_mode[i] = 0; e_valid[i] = 0;
            e_scnt[i] = 0; e_ecnt[i] = 0; e_code[i] = 0;
            return;
        end
        if (offrun[i] >= idle_c[i]) begin
            e_mode[i]  = 0;
            e_valid[i] = 0;
        end
        k = kind[i];
        if (k == K_SYNC) begin
            if (o == 6'd0) kind[i] = K_IDLE;
        end else if (k == K_IDLE) begin
            if (o != 6'd0) begin
                if (!seen[i]) begin
                    kind[i] = K_SYNC;
                end else begin
                    if (starter(o) == 0) fault = 4;
                    resync(i, o);
                end
            end
        end else begin
            if (o == seq[k][pos[i]]) begin
                run[i]++;
                if (run[i] > step_c[i]) begin
                    fault = 2;
                    resync(i, o);
                end
            end else if (run[i] < step_c[i]) begin
                fault = 3;
                resync(i, o);
            end else if (pos[i] + 1 < seq_len[k]) begin
                if (o == seq[k][pos[i]+1]) begin
                    pos[i]++;
                    run[i] = 1;
                end else begin
                    fault = 1;
                    resync(i, o);
                end
            end else if (o == 6'd0) begin
                e_done[i]  = 1;
                e_mode[i]  = k;
                e_valid[i] = 1;
                kind[i]    = K_IDLE;
            end else begin
                fault = 1;
                resync(i, o);
            end
        end
        if (fault != 0) begin
            e_err[i]  = 1;
            e_code[i] = fault;
            if (e_ecnt[i] < max_c[i]) e_ecnt[i]++;
        end
        if (e_done[i] != 0 && e_scnt[i] < max_c[i]) e_scnt[i]++;
        if (o == 6'd0) begin
            seen[i] = 1'b1;
            if (offrun[i] < idle_c[i]) offrun[i]++;
        end else begin
            offrun[i] = 0;
        end
    endtask

    task automatic compare();
        chk("u0.mode",  bus0.mode,       e_mode[0]);
        chk("u0.valid", bus0.mode_valid, e_valid[0]);
        chk("u0.done",  bus0.sweep_done, e_done[0]);
        chk("u0.err",   bus0.err,        e_err[0]);
        chk("u0.scnt",  bus0.sweep_cnt,  e_scnt[0]);
        chk("u0.ecnt",  bus0.err_cnt,    e_ecnt[0]);
        chk("u1.mode",  bus1.mode,       e_mode[1]);
        chk("u1.valid", bus1.mode_valid, e_valid[1]);
        chk("u1.done",  bus1.sweep_done, e_done[1]);
        chk("u1.err",   bus1.err,        e_err[1]);
        chk("u1.scnt",  bus1.sweep_cnt,  e_scnt[1]);
        chk("u1.ecnt",  bus1.err_cnt,    e_ecnt[1]);
`ifdef TLDEC_ERRCODE_EN
        chk("u0.code",  bus0.err_code,   e_code[0]);
        chk("u1.code",  bus1.err_code,   e_code[1]);
`endif
    endtask

    task automatic cycle(input logic [5:0] o, input bit r);
        bus0.li = o[5:3];
        bus0.ri = o[2:0];
        bus1.li = o[5:3];
        bus1.ri = o[2:0];
        rst     = r;
        @(posedge clk);
        #1;
        model(0, o, r);
        model(1, o, r);
        compare();
    endtask

    task automatic play(input logic [5:0] o, input int n);
        for (int j = 0; j < n; j++) cycle(o, 1'b1);
    endtask

    int act;
    int kk;

    initial begin
        seq[1][0] = {PAT_1, PAT_OFF};
        seq[1][1] = {PAT_2, PAT_OFF};
        seq[1][2] = {PAT_3, PAT_OFF};
        seq[2][0] = {PAT_OFF, PAT_1};
        seq[2][1] = {PAT_OFF, PAT_2};
        seq[2][2] = {PAT_OFF, PAT_3};
        seq[3][0] = {PAT_3, PAT_3};
        seq[3][1] = 6'd0;
        seq[3][2] = 6'd0;
        bus0.li = '0; bus0.ri = '0;
        bus1.li = '0; bus1.ri = '0;

        cycle(6'b111111, 1'b0);
        cycle(6'b111111, 1'b0);
        chk("rst.mode", bus0.mode, 0);
        chk("rst.scnt", bus0.sweep_cnt, 0);
        cycle(6'b111111, 1'b1);
        chk("rel.err", bus0.err, 0);
        play(6'b000000, 1);

        play(6'b001000, 1);
        play(6'b011000, 1);
        play(6'b111000, 1);
        chk("left.nodone", bus0.sweep_done, 0);
        play(6'b000000, 1);
        chk("left.done", bus0.sweep_done, 1);
        chk("left.mode", bus0.mode, 1);
        chk("left.scnt", bus0.sweep_cnt, 1);

        play(6'b001000, 1);
        play(6'b111000, 1);
        chk("skip.err", bus0.err, 1);
        chk("skip.ecnt", bus0.err_cnt, 1);
        chk("skip.mode", bus0.mode, 1);
        play(6'b000000, 1);
        chk("skip.quiet", bus0.err, 0);

        play(6'b000001, 1);
        play(6'b000011, 1);
        play(6'b000111, 1);
        play(6'b000000, 1);
        chk("right.mode", bus0.mode, 2);
        play(6'b111111, 1);
        chk("haz.keep", bus0.mode, 2);
        play(6'b000000, 1);
        chk("haz.mode", bus0.mode, 3);
        chk("haz.scnt", bus0.sweep_cnt, 3);

        play(6'b000000, 3);
        chk("idle.held", bus0.mode, 3);
        play(6'b000000, 1);
        chk("idle.mode", bus0.mode, 0);
        chk("idle.valid", bus0.mode_valid, 0);
        chk("idle.scnt", bus0.sweep_cnt, 3);

        play(6'b001000, 2);
        chk("over.ok", bus1.err, 0);
        play(6'b001000, 1);
        chk("over.err", bus1.err, 1);
`ifdef TLDEC_ERRCODE_EN
        chk("over.code", bus1.err_code, 2);
`endif
        play(6'b000000, 1);
        play(6'b001000, 1);
        play(6'b011000, 1);
        chk("under.err", bus1.err, 1);
`ifdef TLDEC_ERRCODE_EN
        chk("under.code", bus1.err_code, 3);
`endif
        play(6'b000000, 1);
        play(6'b001000, 2);
        play(6'b011000, 2);
        play(6'b111000, 2);
        play(6'b000000, 1);
        chk("slow.done", bus1.sweep_done, 1);
        chk("slow.mode", bus1.mode, 1);

        for (int n = 0; n < 300; n++) begin
            act = $urandom_range(0, 19);
            if (act == 0) begin
                cycle(6'd0, 1'b0);
            end else if (act < 3) begin
                play(6'($urandom), $urandom_range(1, 2));
            end else begin
                kk = $urandom_range(1, 3);
                for (int p = 0; p < seq_len[kk]; p++) begin
                    play(seq[kk][p], $urandom_range(1, 3));
                end
                play(6'd0, $urandom_range(0, 5));
            end
        end

        cycle(6'd0, 1'b0);
        play(6'd0, 1);
        for (int n = 0; n < 260; n++) begin
            play(6'b001000, 1);
            play(6'b111000, 1);
            play(6'b000000, 1);
        end
        chk("sat.ecnt", bus0.err_cnt, 255);
        for (int n = 0; n < 260; n++) begin
            play(6'b111111, 1);
            play(6'b000000, 1);
        end
        chk("sat.scnt", bus0.sweep_cnt, 255);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
